reg_pipeline: RTL and testbench



---
 rtl/reg_pipeline.sv | 84 ++++++++
 tb/tb_reg_pipeline.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage valid/ready register pipeline with collapsing
// bubbles, registered occupancy count and synchronous flush.
module reg_pipeline #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_n;
  logic [DEPTH-1:0] load;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt_n;

  // Stage k is ready when out_ready is high or any stage from k to the end is empty.
  always_comb begin
    logic all_full;
    rdy        = '0;
    all_full   = 1'b1;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_full = all_full & v[k];
      rdy[k]   = out_ready | ~all_full;
    end
  end

  assign in_ready = rdy[0] & ~flush;

  // Transfers into each stage, next valid bits and next occupancy; flush wins.
  always_comb begin
    load    = '0;
    v_n     = '0;
    cnt_n   = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = v[k-1] & rdy[k] & ~flush;
    end
    if (!flush) begin
      v_n = load | (v & ~rdy[DEPTH-1:0]);
    end
    for (int k = 0; k < DEPTH; k++) begin
      cnt_n = cnt_n + CW'(v_n[k]);
    end
  end

  // Stage registers: valid bits and count follow v_n, data loads only on transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v     <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      v     <= v_n;
      count <= cnt_n;
      if (load[0]) begin
        d[0] <= data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          d[k] <= d[k-1];
        end
      end
    end
  end

  assign out_valid = v[DEPTH-1];
  assign q         = d[DEPTH-1];

endmodule

// File: tb/tb_reg_pipeline.sv
// Scoreboard bench for reg_pipeline (WIDTH=4, DEPTH=3): the driver pushes
// expected words as it issues them, the monitor pops on every output transfer.
module tb_reg_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] q;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  reg_pipeline #(.WIDTH(4), .DEPTH(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the next falling edge, where outputs are sampled.
  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got q=%0h with empty scoreboard at %0t", q, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          bad++;
          $display("FAIL out_word: got %0h expected %0h at %0t", q, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'($urandom);
    data      = 4'($urandom);
    out_ready = 1'($urandom);
    #3;
    chk("rst_q", q, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'($urandom);
    data     = 4'($urandom);
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    mid();
    chk("rel_q", q, 4'b0000);
    chk("rel_out_valid", out_valid, 1'b0);
    chk("rel_count", count, 2'd0);

    // Latency: single word 1010 with out_ready=1.
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data      = 4'b1010;
    exp_q.push_back(4'b1010);
    mid();
    chk("lat_in_ready", in_ready, 1'b1);
    tick();                       // E0
    in_valid = 1'b0;
    mid();
    chk("lat_count_e0", count, 2'd1);
    chk("lat_ov_e0", out_valid, 1'b0);
    tick();                       // E0+1
    mid();
    chk("lat_count_e1", count, 2'd1);
    chk("lat_ov_e1", out_valid, 1'b0);
    tick();                       // E0+2
    mid();
    chk("lat_count_e2", count, 2'd1);
    chk("lat_ov_e2", out_valid, 1'b1);
    chk("lat_q_e2", q, 4'b1010);
    tick();                       // E0+3
    mid();
    chk("lat_count_e3", count, 2'd0);
    chk("lat_ov_e3", out_valid, 1'b0);

    // Backpressure fill.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      data = 4'(i);
      exp_q.push_back(4'(i));
      tick();
    end
    data = 4'b0100;
    exp_q.push_back(4'b0100);
    mid();
    chk("bp_count", count, 2'd3);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_ov", out_valid, 1'b1);
    chk("bp_q", q, 4'b0001);
    tick();
    mid();
    chk("bp_q_hold", q, 4'b0001);
    chk("bp_ov_hold", out_valid, 1'b1);
    chk("bp_count_hold", count, 2'd3);

    // Drain at full rate; 0100 accepted as out_ready rises.
    tick();
    out_ready = 1'b1;
    mid();
    chk("dr_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    mid();
    chk("dr_count_a", count, 2'd3);
    chk("dr_q_a", q, 4'b0010);
    tick();
    mid();
    chk("dr_count_b", count, 2'd2);
    chk("dr_q_b", q, 4'b0011);
    tick();
    mid();
    chk("dr_count_c", count, 2'd1);
    chk("dr_q_c", q, 4'b0100);
    tick();
    mid();
    chk("dr_count_d", count, 2'd0);
    chk("dr_ov_d", out_valid, 1'b0);

    // Bubble collapse.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data      = 4'b0101;
    exp_q.push_back(4'b0101);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    data     = 4'b0110;
    exp_q.push_back(4'b0110);
    mid();
    chk("bc_in_ready_a", in_ready, 1'b1);
    tick();
    data = 4'b0111;
    exp_q.push_back(4'b0111);
    mid();
    chk("bc_in_ready_b", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    mid();
    chk("bc_count", count, 2'd3);
    chk("bc_in_ready_full", in_ready, 1'b0);
    chk("bc_q", q, 4'b0101);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    mid();
    chk("bc_count_empty", count, 2'd0);
    chk("bc_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with two words inside, one of them at the output.
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data      = 4'b1000;
    tick();
    data = 4'b1001;
    tick();
    in_valid = 1'b0;
    tick();
    mid();
    chk("fl_count_pre", count, 2'd2);
    chk("fl_q_pre", q, 4'b1000);
    tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    data     = 4'b1011;
    mid();
    chk("fl_in_ready", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    mid();
    chk("fl_count", count, 2'd0);
    chk("fl_ov", out_valid, 1'b0);
    chk("fl_q_hold", q, 4'b1000);
    tick();
    mid();
    chk("fl_count_after", count, 2'd0);

    // Refill, then asynchronous reset between edges.
    tick();
    in_valid = 1'b1;
    data     = 4'b1100;
    tick();
    data = 4'b1101;
    tick();
    in_valid = 1'b0;
    mid();
    chk("ar_count_pre", count, 2'd2);
    tick();
    #1;
    reset = 1'b0;
    #1;
    chk("ar_q", q, 4'b0000);
    chk("ar_count", count, 2'd0);
    chk("ar_ov", out_valid, 1'b0);
    chk("ar_in_ready", in_ready, 1'b1);
    #1;
    reset = 1'b1;

    // Resume after reset: one word through with a bounded wait.
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data      = 4'b1110;
    exp_q.push_back(4'b1110);
    tick();
    in_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        tick();
        n++;
      end
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL resume_timeout: %0d words still expected after %0d cycles", exp_q.size(), n);
      end
    end
    tick();
    mid();
    chk("end_count", count, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
